// File: rtl/fm_pkg.sv
// Shared FM/FSK definitions: demodulator state encoding, default RX parameters
// and the NCO tuning words used by the matching transmitter.
package fm_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } demod_state_t;

  localparam int unsigned DEMOD_PERIODS     = 64;
  localparam int unsigned DEMOD_CNT_W       = 16;
  localparam int unsigned DEMOD_THRESH_200M = 2560;
  localparam int unsigned DEMOD_HYST        = 8;
  localparam int unsigned DEMOD_TIMEOUT     = 255;

  // 32-bit phase increments at 200 MHz: low tone ~4.95 MHz, high tone ~5.05 MHz
  localparam int unsigned NCO_W = 32;
  localparam logic [NCO_W-1:0] NCO_TW_LOW_TONE  = 32'd106300441;
  localparam logic [NCO_W-1:0] NCO_TW_HIGH_TONE = 32'd108447924;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a registered
// rising-edge pulse taken one flop further down the chain.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      prev   <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      meta   <= async_i;
      sync   <= meta;
      prev   <= sync;
      rise_o <= sync & ~prev;
    end
  end

  assign level_o = sync;

endmodule

// File: rtl/fsk_period_demod.sv
// FSK demodulator: times a fixed number of received carrier periods in clk
// cycles and slices the count against a hysteresis band to recover the bit.
module fsk_period_demod
  import fm_pkg::*;
#(
  parameter int unsigned PERIODS = DEMOD_PERIODS,
  parameter int unsigned CNT_W   = DEMOD_CNT_W,
  parameter int unsigned THRESH  = DEMOD_THRESH_200M,
  parameter int unsigned HYST    = DEMOD_HYST,
  parameter int unsigned TIMEOUT = DEMOD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_fm_i,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             carrier_ok_o
);

  localparam int unsigned EDGE_W = $clog2(PERIODS);
  localparam int unsigned GAP_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CMP_W  = CNT_W + 1;

  // Slicer limits, one bit wider than the count; lower limit clamps at zero
  localparam logic [CMP_W-1:0] HI_LIM = CMP_W'(THRESH + HYST);
  localparam logic [CMP_W-1:0] LO_LIM = (THRESH > HYST) ? CMP_W'(THRESH - HYST) : '0;

  demod_state_t      state;
  logic [CNT_W-1:0]  win_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              rx_rise;
  logic              rx_level_unused;

  logic [CNT_W-1:0]  win_inc_c;
  logic [CMP_W-1:0]  cmp_c;
  logic              gap_hit_c;
  logic              win_done_c;

  edge_sync u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rx_fm_i),
    .level_o (rx_level_unused),
    .rise_o  (rx_rise)
  );

  assign win_inc_c  = (win_cnt == {CNT_W{1'b1}}) ? win_cnt : win_cnt + CNT_W'(1);
  assign cmp_c      = {1'b0, win_inc_c};
  assign gap_hit_c  = (gap_cnt >= GAP_W'(TIMEOUT));
  assign win_done_c = (edge_cnt == EDGE_W'(PERIODS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ACQUIRE;
      win_cnt      <= '0;
      edge_cnt     <= '0;
      gap_cnt      <= '0;
      bit_o        <= 1'b0;
      bit_valid_o  <= 1'b0;
      count_o      <= '0;
      carrier_ok_o <= 1'b0;
    end else begin
      bit_valid_o <= 1'b0;

      // Edge watchdog
      if (rx_rise) begin
        gap_cnt <= '0;
      end else if (gap_cnt != {GAP_W{1'b1}}) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      case (state)
        ACQUIRE, LOST: begin
          if (rx_rise) begin
            state    <= MEASURE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
        end
        MEASURE: begin
          if (rx_rise) begin
            if (win_done_c) begin
              // Window closes on this edge; the next window starts without a gap
              count_o      <= win_inc_c;
              bit_valid_o  <= 1'b1;
              carrier_ok_o <= 1'b1;
              win_cnt      <= '0;
              edge_cnt     <= '0;
              if (cmp_c > HI_LIM) begin
                bit_o <= 1'b1;
              end else if (cmp_c < LO_LIM) begin
                bit_o <= 1'b0;
              end
            end else begin
              edge_cnt <= edge_cnt + EDGE_W'(1);
              win_cnt  <= win_inc_c;
            end
          end else if (gap_hit_c) begin
            state        <= LOST;
            carrier_ok_o <= 1'b0;
            win_cnt      <= '0;
            edge_cnt     <= '0;
          end else begin
            win_cnt <= win_inc_c;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_period_demod.sv
// Directed bench for fsk_period_demod: tone measurement, hysteresis slicing,
// carrier loss/reacquire, reset behaviour and window saturation.
module tb_fsk_period_demod;

  localparam int CLK_HALF = 2500;
  localparam int CLK_P    = 5000;
  localparam int BUDGET   = 3000;

  // Half periods of the received tone, in the same units as the clock
  localparam int HALF_495 = 101010;
  localparam int HALF_505 = 99010;
  localparam int HALF_500 = 100000;

  localparam int ALT_N = 6;
  localparam int ALT_HALF [ALT_N] = '{101010, 100000, 99010, 100000, 100586, 99414};
  localparam int ALT_LO   [ALT_N] = '{2585, 2559, 2534, 2559, 2574, 2544};
  localparam int ALT_HI   [ALT_N] = '{2587, 2561, 2536, 2561, 2576, 2546};
  localparam bit ALT_BIT  [ALT_N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_man = 1'b0;
  logic        rx_gen = 1'b0;
  logic        rx_fm;
  logic        bit_o;
  logic        bit_valid;
  logic [15:0] count;
  logic        carrier_ok;

  logic        sat_reset = 1'b1;
  logic        sat_rx = 1'b0;
  logic        sat_bit;
  logic        sat_valid;
  logic [9:0]  sat_count;
  logic        sat_ok;

  bit  rx_run = 1'b0;
  int  half = HALF_495;
  time last_rise_t = 0;
  int  tests = 0;
  int  fails = 0;
  int  strobe_cnt = 0;
  int  sat_strobes = 0;
  int  rx_rises = 0;

  assign rx_fm = rx_gen | rx_man;

  fsk_period_demod dut (
    .clk          (clk),
    .reset        (reset),
    .rx_fm_i      (rx_fm),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid),
    .count_o      (count),
    .carrier_ok_o (carrier_ok)
  );

  fsk_period_demod #(
    .PERIODS (2),
    .CNT_W   (10),
    .THRESH  (500),
    .HYST    (8),
    .TIMEOUT (1000)
  ) dut_sat (
    .clk          (clk),
    .reset        (sat_reset),
    .rx_fm_i      (sat_rx),
    .bit_o        (sat_bit),
    .bit_valid_o  (sat_valid),
    .count_o      (sat_count),
    .carrier_ok_o (sat_ok)
  );

  always #(CLK_HALF) clk = ~clk;

  // Tone generator: finishes the current period when stopped
  initial begin
    forever begin
      if (rx_run) begin
        rx_gen = 1'b1;
        last_rise_t = $time;
        #(half);
        rx_gen = 1'b0;
        #(half);
      end else begin
        @(posedge clk);
      end
    end
  end

  always @(posedge rx_fm) rx_rises++;
  always @(negedge clk) if (bit_valid === 1'b1) strobe_cnt++;
  always @(negedge clk) if (sat_valid === 1'b1) sat_strobes++;

  task automatic wait_strobe(output bit got);
    got = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (bit_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    int base;
    reset = 1'b1;
    rx_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_man = ~rx_man;
    end
    tests++; if (bit_o !== 1'b0) begin fails++; $display("FAIL reset_bit: got %0b want 0", bit_o); end
    tests++; if (bit_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", bit_valid); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (carrier_ok !== 1'b0) begin fails++; $display("FAIL reset_carrier: got %0b want 0", carrier_ok); end
    rx_man = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    base = rx_rises;
    half = HALF_495;
    rx_run = 1'b1;
    wait_strobe(got);
    tests++; if (!got) begin fails++; $display("FAIL first_strobe: no strobe within %0d clk", BUDGET); end
    tests++;
    if (rx_rises - base != 65) begin
      fails++; $display("FAIL first_strobe_edges: got %0d edges want 65", rx_rises - base);
    end
    tests++;
    if (count < 16'd2585 || count > 16'd2587) begin
      fails++; $display("FAIL first_count: got %0d want 2585..2587", count);
    end
    tests++; if (bit_o !== 1'b1) begin fails++; $display("FAIL first_bit: got %0b want 1", bit_o); end
    tests++; if (carrier_ok !== 1'b1) begin fails++; $display("FAIL first_carrier: got %0b want 1", carrier_ok); end
  endtask

  task automatic test_low_tone();
    bit got;
    half = HALF_495;
    for (int w = 0; w < 2; w++) begin
      wait_strobe(got);
      tests++; if (!got) begin fails++; $display("FAIL low_strobe: window %0d missing", w); end
      tests++;
      if (count < 16'd2585 || count > 16'd2587) begin
        fails++; $display("FAIL low_count: got %0d want 2585..2587", count);
      end
      tests++; if (bit_o !== 1'b1) begin fails++; $display("FAIL low_bit: got %0b want 1", bit_o); end
      tests++; if (carrier_ok !== 1'b1) begin fails++; $display("FAIL low_carrier: got %0b want 1", carrier_ok); end
    end
  endtask

  task automatic test_high_tone();
    bit got;
    half = HALF_505;
    wait_strobe(got);
    tests++; if (!got) begin fails++; $display("FAIL high_settle: strobe missing"); end
    for (int w = 0; w < 2; w++) begin
      wait_strobe(got);
      tests++; if (!got) begin fails++; $display("FAIL high_strobe: window %0d missing", w); end
      tests++;
      if (count < 16'd2534 || count > 16'd2536) begin
        fails++; $display("FAIL high_count: got %0d want 2534..2536", count);
      end
      tests++; if (bit_o !== 1'b0) begin fails++; $display("FAIL high_bit: got %0b want 0", bit_o); end
    end
  endtask

  // Each step: one transitional window, then one fully-settled window checked
  task automatic test_alternate();
    bit got;
    for (int k = 0; k < ALT_N; k++) begin
      half = ALT_HALF[k];
      wait_strobe(got);
      tests++; if (!got) begin fails++; $display("FAIL alt_settle: step %0d strobe missing", k); end
      wait_strobe(got);
      tests++; if (!got) begin fails++; $display("FAIL alt_strobe: step %0d strobe missing", k); end
      tests++;
      if (int'(count) < ALT_LO[k] || int'(count) > ALT_HI[k]) begin
        fails++; $display("FAIL alt_count: step %0d got %0d want %0d..%0d", k, count, ALT_LO[k], ALT_HI[k]);
      end
      tests++;
      if (bit_o !== ALT_BIT[k]) begin
        fails++; $display("FAIL alt_bit: step %0d got %0b want %0b", k, bit_o, ALT_BIT[k]);
      end
    end
  endtask

  task automatic test_lost();
    bit  got;
    int  s0;
    time t0;
    int  n;
    wait_strobe(got);
    tests++; if (!got) begin fails++; $display("FAIL lost_start: strobe missing"); end
    repeat (800) @(negedge clk);
    rx_run = 1'b0;
    s0 = strobe_cnt;
    repeat (60) @(negedge clk);
    t0 = last_rise_t;
    n = 0;
    while (($time - t0) < time'(250 * CLK_P) && n < 400) begin @(negedge clk); n++; end
    tests++; if (carrier_ok !== 1'b1) begin fails++; $display("FAIL lost_early: carrier got %0b want 1", carrier_ok); end
    n = 0;
    while (($time - t0) < time'(264 * CLK_P) && n < 400) begin @(negedge clk); n++; end
    tests++; if (carrier_ok !== 1'b0) begin fails++; $display("FAIL lost_drop: carrier got %0b want 0", carrier_ok); end
    n = 0;
    while (($time - t0) < time'(300 * CLK_P) && n < 400) begin @(negedge clk); n++; end
    tests++; if (strobe_cnt != s0) begin fails++; $display("FAIL lost_strobe: got %0d strobes want 0", strobe_cnt - s0); end
    tests++; if (bit_o !== 1'b0) begin fails++; $display("FAIL lost_hold: bit got %0b want 0", bit_o); end
    half = HALF_495;
    rx_run = 1'b1;
    repeat (100) @(negedge clk);
    tests++; if (carrier_ok !== 1'b0) begin fails++; $display("FAIL reacq_early: carrier got %0b want 0", carrier_ok); end
    wait_strobe(got);
    tests++; if (!got) begin fails++; $display("FAIL reacq_strobe: strobe missing"); end
    tests++;
    if (count < 16'd2585 || count > 16'd2587) begin
      fails++; $display("FAIL reacq_count: got %0d want 2585..2587", count);
    end
    tests++; if (bit_o !== 1'b1) begin fails++; $display("FAIL reacq_bit: got %0b want 1", bit_o); end
    tests++; if (carrier_ok !== 1'b1) begin fails++; $display("FAIL reacq_carrier: got %0b want 1", carrier_ok); end
  endtask

  task automatic test_reset_mid();
    bit got;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bit_o !== 1'b0) begin fails++; $display("FAIL mid_reset_bit: got %0b want 0", bit_o); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL mid_reset_count: got %0d want 0", count); end
    tests++; if (carrier_ok !== 1'b0) begin fails++; $display("FAIL mid_reset_carrier: got %0b want 0", carrier_ok); end
    tests++; if (bit_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %0b want 0", bit_valid); end
    @(negedge clk);
    reset = 1'b0;
    wait_strobe(got);
    tests++; if (!got) begin fails++; $display("FAIL post_reset_strobe: strobe missing"); end
    tests++; if (carrier_ok !== 1'b1) begin fails++; $display("FAIL post_reset_carrier: got %0b want 1", carrier_ok); end
    wait_strobe(got);
    tests++;
    if (!got || count < 16'd2585 || count > 16'd2587) begin
      fails++; $display("FAIL post_reset_count: got %0d want 2585..2587", count);
    end
  endtask

  // Narrow-counter instance: two 600-clk periods overflow a 10-bit window
  task automatic test_saturation();
    bit got;
    @(negedge clk);
    sat_reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      sat_rx = 1'b1;
      repeat (300) @(negedge clk);
      sat_rx = 1'b0;
      repeat (300) @(negedge clk);
    end
    tests++; if (sat_strobes != 0) begin fails++; $display("FAIL sat_early: got %0d strobes want 0", sat_strobes); end
    sat_rx = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sat_valid === 1'b1) begin got = 1'b1; break; end
    end
    tests++; if (!got) begin fails++; $display("FAIL sat_strobe: strobe missing"); end
    tests++; if (sat_count !== 10'h3FF) begin fails++; $display("FAIL sat_count: got %0h want 3ff", sat_count); end
    tests++; if (sat_bit !== 1'b1) begin fails++; $display("FAIL sat_bit: got %0b want 1", sat_bit); end
    tests++; if (sat_ok !== 1'b1) begin fails++; $display("FAIL sat_carrier: got %0b want 1", sat_ok); end
  endtask

  initial begin
    #1000000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_low_tone();
    test_high_tone();
    test_alternate();
    test_lost();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
